dmem_bram: RTL
==============

# dmem_bram

Parametrised, byte-lane-writable synchronous data memory for the core's load/store path, successor to the fixed 64K×32 data-RAM behavioural model. It adds a valid/ready request port, a configurable read pipeline, per-byte write enables and an optional post-reset clear sweep. It sits behind the MEM stage and serves as a drop-in simulation model or as synthesisable inferred block RAM.

## Interface

Parameters:
- ADDR_W, 16, word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- LATENCY, 1, read pipeline depth in cycles, legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after every reset; 0 = contents retained across reset.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NB  byte-lane write enables; bit i covers data bits [8i+7:8i].
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response word valid.
- rsp_rdata  out  DATA_W  response data.

## Operation

- A request is accepted on a rising edge where req_valid && req_ready.
- Every accepted request, read or write, produces exactly one response. Responses return in order with no backpressure.
- Read: rsp_rdata = mem[req_addr] as sampled at the acceptance edge.
- Write: at the acceptance edge, for each i with req_be[i]=1, lane i of mem[req_addr] takes lane i of req_wdata. Other lanes are unchanged.
- A write with req_be=0 changes no lanes but still responds.
- Write response data is the word before the write (read-first).
- A read accepted on the edge after a write to the same address returns the new data.
- FSM states:
  - RESET: while rst=1.
  - CLEAR: entered from RESET when CLEAR_ON_RESET=1. A counter clr_addr runs 0..DEPTH-1, writing all-zero to one word per edge. Exit to RUN on the edge that writes word DEPTH-1.
  - RUN: entered directly from RESET when CLEAR_ON_RESET=0. req_ready=1 only in RUN.
- rst=1 in any state returns to RESET at that edge: clr_addr back to 0, all pipeline valid bits cleared.
- Reset never modifies array contents. An interrupted clear restarts from word 0.
- The initial array content at time 0 is all-zero, for simulation.
- No address bounds check is needed: the address width equals the array span.

## Timing

- Reset values (the cycle after an edge with rst=1): req_ready=0, rsp_valid=0, rsp_rdata=0, clr_addr=0.
- The read launches at the acceptance edge into pipeline stage 1; each subsequent edge advances one stage.
- rsp_valid and rsp_rdata appear exactly LATENCY cycles after the acceptance edge and hold for one cycle.
- With LATENCY=1, the response is visible in the cycle right after acceptance.
- Throughput is one request per cycle in RUN, with back-to-back accepts of any read/write mix.
- rsp_rdata holds its last value when rsp_valid=0. It is cleared only by reset.
- Clear timing:
  - Edges k=0..DEPTH-1 with rst=0 write word k.
  - req_ready=1 from the cycle following edge DEPTH-1, i.e. DEPTH cycles after rst is released.
- CLEAR_ON_RESET=0: req_ready=1 in the first cycle after rst deasserts.
- Requests with req_ready=0 are ignored: no write, no response. Requesters must hold req_valid.
- A reset asserted while responses are in flight drops them. rsp_valid=0 from the next cycle.

## Configuration

- DMEM_TRACE_EN defined: each accepted request prints one $display line at the acceptance edge.
  - Write: "<time> | 0x<addr> <| 0x<wdata> |[MEM W] be=<be>".
  - Read: "<time> | 0x<addr> |> 0x<rdata> |[MEM R]".
  - No prints during RESET, during CLEAR, or on idle cycles.
- DMEM_TRACE_EN undefined: no display statements are compiled. Logic is identical and synthesisable.

## Test plan

Bench parameters: ADDR_W=4, DATA_W=32, LATENCY=2, CLEAR_ON_RESET=1 unless stated.

- Release rst after 3 cycles, hold req_valid=1 as a read of addr 5.
  - Required: req_ready=0 for 16 cycles, then 1.
  - Required: rsp_valid pulses 2 cycles after acceptance with rsp_rdata=0x00000000.
- Write 0xDEADBEEF to addr 3 with be=1111, then read addr 3.
  - Required: write response 0x00000000.
  - Required: read response 0xDEADBEEF.
- Write 0x0000AA00 to addr 3 with be=0010, then read addr 3.
  - Required: read response 0xDEADAAEF.
  - Also issue a be=0000 write of 0xFFFFFFFF to addr 3; the next read still returns 0xDEADAAEF.
- Back-to-back accepts: write 0x12345678 to addr 7 (old value 0), read addr 7 on the next cycle, read addr 3 on the cycle after.
  - Required: responses on 3 consecutive cycles: 0x00000000, 0x12345678, 0xDEADAAEF.
- Pulse rst for one cycle, first with 2 responses in flight, then mid-clear at clr_addr=9.
  - Required: rsp_valid=0 the next cycle, with no late responses.
  - Required: after the mid-clear reset, the clear restarts and req_ready rises 16 cycles after release.
  - Required: every word reads 0 afterwards.
- CLEAR_ON_RESET=0: write 0xCAFEF00D to addr 2, pulse rst, then read addr 2.
  - Required: req_ready=1 in the first cycle after reset.
  - Required: read response 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_bram.sv
// dmem_bram: byte-lane-writable data memory with valid/ready request port, LATENCY-deep read pipeline and optional post-reset clear sweep; define DMEM_TRACE_EN to print one line per accepted request
module dmem_bram #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int LATENCY        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [DATA_W/8-1:0]    req_be,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {RESET, CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                clr_en;
    logic                acc;
    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0]   dat_q [LATENCY];
    logic [DATA_W-1:0]   dat_d [LATENCY];
    logic [DATA_W-1:0]   mem   [DEPTH] = '{default: '0};

    // Control: the clear sweep runs from the first edge after reset until word DEPTH-1 is written
    always_comb begin
        req_ready  = state_q == RUN;
        clr_en     = (CLEAR_ON_RESET != 0) && state_q != RUN;
        acc        = req_valid && req_ready && !rst;
        clr_addr_d = clr_en ? clr_addr_q + 1'b1 : clr_addr_q;
        state_d    = (state_q == RUN || !clr_en || clr_addr_q == '1) ? RUN : CLEAR;
    end

    // Read pipeline: stage 0 captures the pre-write word at acceptance; stages only load on a valid so the last one holds
    always_comb begin
        vld_d[0] = acc;
        dat_d[0] = acc ? mem[req_addr] : dat_q[0];
        for (int j = 1; j < LATENCY; j++) begin
            vld_d[j] = vld_q[j-1];
            dat_d[j] = vld_q[j-1] ? dat_q[j-1] : dat_q[j];
        end
    end

    // State, clear counter and pipeline registers; reset drops in-flight responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET;
            clr_addr_q <= '0;
            vld_q      <= '0;
            dat_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
        end
    end

    // Array writes: clear sweep or byte-lane store; reset itself never touches contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en)
                mem[clr_addr_q] <= '0;
            else if (acc && req_we)
                for (int i = 0; i < NB; i++)
                    if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
    end

    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_rdata = dat_q[LATENCY-1];

`ifdef DMEM_TRACE_EN
    // Request trace, one line per accepted request
    always_ff @(posedge clk) begin
        if (acc) begin
            if (req_we)
                $display("%0t | 0x%h <| 0x%h |[MEM W] be=%b", $time, req_addr, req_wdata, req_be);
            else
                $display("%0t | 0x%h |> 0x%h |[MEM R]", $time, req_addr, mem[req_addr]);
        end
    end
`else
`endif
endmodule
